// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: sequencer state encoding, register-write command header, USB3300 register map.
package ulpi_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ACK     = 3'd2,
        ST_BUSY    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } seq_state_t;

    localparam logic [1:0] ULPI_CMD_REGW = 2'b10;

    localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
    localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;
    localparam logic [5:0] REG_IFC_CTRL  = 6'h07;

endpackage

// File: rtl/ulpi_seq_timer.sv
// 8-bit loadable down-counter, saturating at zero; zero flag is combinational from the count.
// Latency: load takes effect on the next edge; count reaches zero value+1 cycles after load.
// Backpressure: none; free-running decrement whenever not loading.
module ulpi_seq_timer #(
    parameter logic [7:0] RST_VAL = 8'd0
) (
    input  logic       clk_ULPI,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk_ULPI) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/ulpi_init_seq.sv
// ULPI PHY power-up sequencer: startup delay, then one register write per table entry with retry.
// Latency: first wr_PrW STARTUP_CYCLES+1 cycles after reset release; 2 cycles from busy fall to next PrW.
// Backpressure: DIR=1 holds the issue; engine busy is bounded by a watchdog that aborts and retries.
module ulpi_init_seq
    import ulpi_pkg::*;
#(
    parameter int                      N_WRITES       = 3,
    parameter logic [N_WRITES*6-1:0]   INIT_ADDRS     = {REG_FUNC_CTRL, REG_OTG_CTRL, REG_IFC_CTRL},
    parameter logic [N_WRITES*8-1:0]   INIT_VALS      = {8'h48, 8'h06, 8'h00},
    parameter int                      STARTUP_CYCLES = 16,
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter int                      MAX_RETRY      = 2
) (
    input  logic       clk_ULPI,
    input  logic       rst,
    input  logic       start,
    input  logic       DIR,
    input  logic       wr_busy,
    output logic       wr_PrW,
    output logic [5:0] wr_ADDR,
    output logic [7:0] wr_REG_VAL,
    output logic       wr_abort,
    output logic [3:0] idx,
    output logic       done,
    output logic       error
);

    if (N_WRITES < 1 || N_WRITES > 16 || STARTUP_CYCLES < 1 || STARTUP_CYCLES > 256 ||
        TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 256 || MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_param
        $error("ulpi_init_seq: parameter out of range");
    end

    localparam logic [3:0] LAST_IDX  = 4'(N_WRITES - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [7:0] ACK_WAIT  = 8'd3;
    localparam logic [7:0] BUSY_WAIT = 8'(TIMEOUT_CYCLES - 1);

    // Table padded to 16 entries so the 4-bit index selects without range issues.
    logic [5:0] addr_tab [16];
    logic [7:0] val_tab  [16];

    for (genvar g = 0; g < 16; g++) begin : g_tab
        if (g < N_WRITES) begin : g_used
            assign addr_tab[g] = INIT_ADDRS[(N_WRITES-1-g)*6 +: 6];
            assign val_tab[g]  = INIT_VALS[(N_WRITES-1-g)*8 +: 8];
        end else begin : g_pad
            assign addr_tab[g] = 6'd0;
            assign val_tab[g]  = 8'd0;
        end
    end

    seq_state_t state, state_nxt;
    logic [3:0] idx_nxt;
    logic [3:0] retry, retry_nxt;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_zero;

    ulpi_seq_timer #(
        .RST_VAL (8'(STARTUP_CYCLES - 1))
    ) u_timer (
        .clk_ULPI (clk_ULPI),
        .rst      (rst),
        .load     (tmr_load),
        .value    (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        retry_nxt = retry;
        tmr_load  = 1'b0;
        tmr_val   = 8'd0;
        case (state)
            ST_STARTUP: if (tmr_zero) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (!DIR) begin
                    tmr_load  = 1'b1;
                    tmr_val   = ACK_WAIT;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (wr_busy) begin
                    tmr_load  = 1'b1;
                    tmr_val   = BUSY_WAIT;
                    state_nxt = ST_BUSY;
                end else if (tmr_zero) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_BUSY: begin
                if (!wr_busy)      state_nxt = ST_NEXT;
                else if (tmr_zero) state_nxt = ST_FAIL;
            end
            ST_FAIL: begin
                if (retry < RETRY_MAX) begin
                    retry_nxt = retry + 4'd1;
                    state_nxt = ST_ISSUE;
                end else begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_NEXT: begin
                retry_nxt = 4'd0;
                if (idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt   = idx + 4'd1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    idx_nxt   = 4'd0;
                    retry_nxt = 4'd0;
                    state_nxt = ST_ISSUE;
                end
            end
            default: state_nxt = ST_STARTUP;
        endcase
    end

    // Address/value registers follow idx on the same edge, so they hold through the whole write.
    always_ff @(posedge clk_ULPI) begin
        if (rst) begin
            state      <= ST_STARTUP;
            idx        <= 4'd0;
            retry      <= 4'd0;
            wr_ADDR    <= addr_tab[0];
            wr_REG_VAL <= val_tab[0];
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            retry      <= retry_nxt;
            wr_ADDR    <= addr_tab[idx_nxt];
            wr_REG_VAL <= val_tab[idx_nxt];
        end
    end

    assign wr_PrW   = (state == ST_ISSUE) && !DIR;
    assign wr_abort = (state == ST_FAIL);
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERROR);

endmodule

// File: tb/tb_ulpi_init_seq.sv
// Bench for ulpi_init_seq with a behavioural register-write engine; scenario table plus directed corner sequences.
module tb_ulpi_init_seq;

    logic       clk_ULPI = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       DIR = 1'b0;
    logic       wr_busy;
    logic       wr_PrW;
    logic [5:0] wr_ADDR;
    logic [7:0] wr_REG_VAL;
    logic       wr_abort;
    logic [3:0] idx;
    logic       done;
    logic       error;

    ulpi_init_seq dut (
        .clk_ULPI   (clk_ULPI),
        .rst        (rst),
        .start      (start),
        .DIR        (DIR),
        .wr_busy    (wr_busy),
        .wr_PrW     (wr_PrW),
        .wr_ADDR    (wr_ADDR),
        .wr_REG_VAL (wr_REG_VAL),
        .wr_abort   (wr_abort),
        .idx        (idx),
        .done       (done),
        .error      (error)
    );

    always #8 clk_ULPI = ~clk_ULPI;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dir_lo = 0;
    int dir_hi = -1;
    int stuck_idx = -1;
    bit drop_first = 1'b0;
    int base_p, base_a;

    // Engine model: busy for 4 cycles after PrW; can swallow the first PrW or hang on one entry until abort.
    logic [1:0] bcnt;
    int         prw_seen;
    always @(posedge clk_ULPI) begin
        if (rst) begin
            wr_busy  <= 1'b0;
            bcnt     <= 2'd0;
            prw_seen <= 0;
        end else if (wr_abort) begin
            wr_busy <= 1'b0;
        end else if (wr_PrW) begin
            prw_seen <= prw_seen + 1;
            if (!(drop_first && prw_seen == 0)) begin
                wr_busy <= 1'b1;
                bcnt    <= 2'd3;
            end
        end else if (wr_busy && int'(idx) != stuck_idx) begin
            if (bcnt == 2'd0) wr_busy <= 1'b0;
            else              bcnt    <= bcnt - 2'd1;
        end
    end

    int         prw_cyc[$];
    logic [5:0] prw_addr[$];
    logic [7:0] prw_val[$];
    int         abort_cyc[$];
    int         viol = 0;
    int         both_cnt = 0;
    always @(negedge clk_ULPI) begin
        if (!rst) begin
            if (wr_PrW) begin
                prw_cyc.push_back(cyc);
                prw_addr.push_back(wr_ADDR);
                prw_val.push_back(wr_REG_VAL);
                if (wr_busy || DIR) viol++;
            end
            if (wr_abort) abort_cyc.push_back(cyc);
            if (done && error) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ULPI);
        #1;
        cyc++;
        DIR = (cyc >= dir_lo && cyc <= dir_hi);
    endtask

    task automatic mark_release();
        rst    = 1'b0;
        cyc    = 1;
        DIR    = (cyc >= dir_lo && cyc <= dir_hi);
        base_p = prw_cyc.size();
        base_a = abort_cyc.size();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        mark_release();
    endtask

    task automatic run_to_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (done || error) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " PrW"},   wr_PrW,     0);
        check({tag, " abort"}, wr_abort,   0);
        check({tag, " done"},  done,       0);
        check({tag, " error"}, error,      0);
        check({tag, " idx"},   idx,        0);
        check({tag, " addr"},  wr_ADDR,    6'h04);
        check({tag, " val"},   wr_REG_VAL, 8'h48);
    endtask

    typedef struct {
        string name;
        int    dlo;
        int    dhi;
        bit    drop;
        int    stuck;
        int    n_prw;
        int    n_abort;
        bit    exp_done;
        bit    exp_err;
        int    exp_idx;
    } vec_t;

    function automatic vec_t mk(input string name, input int dlo, input int dhi, input bit drop,
                                input int stuck, input int n_prw, input int n_abort,
                                input bit exp_done, input bit exp_err, input int exp_idx);
        vec_t v;
        v.name = name;  v.dlo = dlo;  v.dhi = dhi;  v.drop = drop;  v.stuck = stuck;
        v.n_prw = n_prw;  v.n_abort = n_abort;  v.exp_done = exp_done;
        v.exp_err = exp_err;  v.exp_idx = exp_idx;
        return v;
    endfunction

    logic [5:0] exp_addr [3];
    logic [7:0] exp_val  [3];

    initial begin
        vec_t vecs[6];
        bit   ok;
        int   s;

        exp_addr[0] = 6'h04;  exp_addr[1] = 6'h0A;  exp_addr[2] = 6'h07;
        exp_val[0]  = 8'h48;  exp_val[1]  = 8'h06;  exp_val[2]  = 8'h00;

        vecs[0] = mk("nominal",  0, -1, 1'b0, -1, 3, 0, 1'b1, 1'b0, 2);
        vecs[1] = mk("dir_hold", 20, 29, 1'b0, -1, 3, 0, 1'b1, 1'b0, 2);
        vecs[2] = mk("stuck1",   0, -1, 1'b0,  1, 4, 3, 1'b0, 1'b1, 1);
        vecs[3] = mk("noack0",   0, -1, 1'b1, -1, 4, 1, 1'b1, 1'b0, 2);
        vecs[4] = mk("stuck0",   0, -1, 1'b0,  0, 3, 3, 1'b0, 1'b1, 0);
        vecs[5] = mk("stuck2",   0, -1, 1'b0,  2, 5, 3, 1'b0, 1'b1, 2);

        for (int i = 0; i < 6; i++) begin
            dir_lo     = vecs[i].dlo;
            dir_hi     = vecs[i].dhi;
            drop_first = vecs[i].drop;
            stuck_idx  = vecs[i].stuck;
            do_reset();
            if (i == 0) check_reset_outputs("reset");
            run_to_end(3000, ok);
            check({vecs[i].name, " finished"}, ok, 1);
            repeat (20) tick();
            check({vecs[i].name, " prw_count"},   prw_cyc.size() - base_p,   vecs[i].n_prw);
            check({vecs[i].name, " abort_count"}, abort_cyc.size() - base_a, vecs[i].n_abort);
            check({vecs[i].name, " done"},  done,  vecs[i].exp_done);
            check({vecs[i].name, " error"}, error, vecs[i].exp_err);
            check({vecs[i].name, " idx"},   idx,   vecs[i].exp_idx);
            case (i)
                0: begin
                    for (int k = 0; k < 3; k++) begin
                        check($sformatf("nominal prw%0d cycle", k), prw_cyc[base_p+k], 17 + 7*k);
                        check($sformatf("nominal prw%0d addr", k),  prw_addr[base_p+k], exp_addr[k]);
                        check($sformatf("nominal prw%0d val", k),   prw_val[base_p+k],  exp_val[k]);
                    end
                end
                1: begin
                    check("dir_hold entry1 cycle", prw_cyc[base_p+1], 30);
                    check("dir_hold entry1 addr",  prw_addr[base_p+1], 6'h0A);
                    check("dir_hold entry2 addr",  prw_addr[base_p+2], 6'h07);
                end
                2: begin
                    check("stuck1 abort cycle",  abort_cyc[base_a], 24 + 257);
                    check("stuck1 retry addr",   prw_addr[base_p+3], 6'h0A);
                end
                3: begin
                    check("noack0 abort cycle",  abort_cyc[base_a], 22);
                    check("noack0 retry cycle",  prw_cyc[base_p+1], 23);
                    check("noack0 retry addr",   prw_addr[base_p+1], 6'h04);
                end
                default: ;
            endcase
        end

        // Rerun after done, with a start pulse during a busy write that must be ignored.
        dir_lo = 0;  dir_hi = -1;  drop_first = 1'b0;  stuck_idx = -1;
        do_reset();
        run_to_end(200, ok);
        check("rerun first pass done", done, 1);
        base_p = prw_cyc.size();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun immediate PrW", wr_PrW, 1);
        check("rerun done cleared",  done,   0);
        check("rerun idx restart",   idx,    0);
        check("rerun addr restart",  wr_ADDR, 6'h04);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (wr_busy && idx == 4'd1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("rerun reached busy entry1", ok, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_end(200, ok);
        repeat (10) tick();
        check("rerun prw_count",  prw_cyc.size() - base_p, 3);
        check("rerun first cycle", prw_cyc[base_p], s + 1);
        check("rerun done",  done, 1);
        check("rerun idx",   idx,  2);

        // Reset in the middle of the last write.
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (wr_busy && idx == 4'd2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("midreset reached busy entry2", ok, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midreset");
        check("midreset engine idle", wr_busy, 0);
        mark_release();
        run_to_end(200, ok);
        check("midreset finished",   ok, 1);
        check("midreset prw_count",  prw_cyc.size() - base_p, 3);
        check("midreset first cycle", prw_cyc[base_p], 17);
        check("midreset first addr",  prw_addr[base_p], 6'h04);
        check("midreset done", done, 1);

        check("prw while busy or DIR", viol, 0);
        check("done and error together", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
